// File: rtl/calendar_pkg.sv
// Shared constants and the leap-year rule for the calendar counter and its
// days-in-month decoder.
package calendar_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    localparam int LEAP_NONE = 0;
    localparam int LEAP_DIV4 = 1;
    localparam int LEAP_GREG = 2;

    // Year is zero-extended by the caller so the rule sees the unsigned register value.
    function automatic logic leap_year(input logic [31:0] y, input int mode);
        logic div4;
        logic div100;
        logic div400;
        div4   = (y % 32'd4)   == 32'd0;
        div100 = (y % 32'd100) == 32'd0;
        div400 = (y % 32'd400) == 32'd0;
        case (mode)
            LEAP_DIV4: leap_year = div4;
            LEAP_GREG: leap_year = div4 && (!div100 || div400);
            default:   leap_year = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/calendar_counter_month_len.sv
// Days-in-month decoder; out-of-range month numbers report zero days so any
// day compared against them is rejected.
module month_len
    import calendar_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dim,
    output logic               is_31
);

    always_comb begin
        dim = 5'd0;
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: dim = 5'd31;
            APR, JUN, SEP, NOV:                dim = 5'd30;
            FEB:                               dim = leap ? 5'd29 : 5'd28;
            default:                           dim = 5'd0;
        endcase
    end

    assign is_31 = (dim == 5'd31);

endmodule

// File: rtl/calendar_counter.sv
// Day/month/year counter advancing one day per tick, with validated date load
// and registered month/year rollover pulses.
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W     = 12,
    parameter int YEAR_RESET = 2000,
    parameter int LEAP_MODE  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               load,
    input  logic [DAY_W-1:0]   load_day,
    input  logic [MONTH_W-1:0] load_month,
    input  logic [YEAR_W-1:0]  load_year,
    output logic [DAY_W-1:0]   day,
    output logic [MONTH_W-1:0] month,
    output logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   dim,
    output logic               is_31,
    output logic               leap,
    output logic               month_wrap,
    output logic               year_wrap,
    output logic               load_err
);

    logic [DAY_W-1:0]   day_reg, day_next;
    logic [MONTH_W-1:0] month_reg, month_next;
    logic [YEAR_W-1:0]  year_reg, year_next;
    logic               month_wrap_reg, month_wrap_next;
    logic               year_wrap_reg, year_wrap_next;
    logic               load_err_reg, load_err_next;

    // Index 0 decodes the current state, index 1 the date offered for load.
    logic [MONTH_W-1:0] sel_month [2];
    logic [YEAR_W-1:0]  sel_year  [2];
    logic               sel_leap  [2];
    logic [DAY_W-1:0]   sel_dim   [2];
    logic               sel_is31  [2];

    assign sel_month[0] = month_reg;
    assign sel_year[0]  = year_reg;
    assign sel_month[1] = load_month;
    assign sel_year[1]  = load_year;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign sel_leap[gi] = leap_year(32'(sel_year[gi]), LEAP_MODE);
            month_len u_month_len (
                .month (sel_month[gi]),
                .leap  (sel_leap[gi]),
                .dim   (sel_dim[gi]),
                .is_31 (sel_is31[gi])
            );
        end
    endgenerate

    logic load_ok;
    assign load_ok = (load_month >= JAN) && (load_month <= DEC) &&
                     (load_day != 5'd0) && (load_day <= sel_dim[1]);

    always_comb begin
        day_next        = day_reg;
        month_next      = month_reg;
        year_next       = year_reg;
        month_wrap_next = 1'b0;
        year_wrap_next  = 1'b0;
        load_err_next   = 1'b0;
        if (load) begin
            // A tick coinciding with a load is dropped whether or not the load is accepted.
            if (load_ok) begin
                day_next   = load_day;
                month_next = load_month;
                year_next  = load_year;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (tick) begin
            if (day_reg < sel_dim[0]) begin
                day_next = day_reg + 5'd1;
            end else begin
                day_next        = 5'd1;
                month_wrap_next = 1'b1;
                if (month_reg == DEC) begin
                    month_next     = JAN;
                    year_next      = year_reg + YEAR_W'(1);
                    year_wrap_next = 1'b1;
                end else begin
                    month_next = month_reg + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_reg        <= 5'd1;
            month_reg      <= JAN;
            year_reg       <= YEAR_W'(YEAR_RESET);
            month_wrap_reg <= 1'b0;
            year_wrap_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
        end else begin
            day_reg        <= day_next;
            month_reg      <= month_next;
            year_reg       <= year_next;
            month_wrap_reg <= month_wrap_next;
            year_wrap_reg  <= year_wrap_next;
            load_err_reg   <= load_err_next;
        end
    end

    assign day        = day_reg;
    assign month      = month_reg;
    assign year       = year_reg;
    assign dim        = sel_dim[0];
    assign is_31      = sel_is31[0];
    assign leap       = sel_leap[0];
    assign month_wrap = month_wrap_reg;
    assign year_wrap  = year_wrap_reg;
    assign load_err   = load_err_reg;

endmodule
